// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: opcode encoding and default width.
package usr_pkg;

   // Default register width.
   localparam int USR_DEFAULT_WIDTH = 4;

   // Operation codes. "Right" moves data toward bit 0.
   typedef enum logic [2:0] {
      OP_HOLD = 3'b000,  // keep current value
      OP_SHR0 = 3'b001,  // shift right, zero into MSB
      OP_SHL0 = 3'b010,  // shift left, zero into LSB
      OP_ROR  = 3'b011,  // rotate right, LSB wraps to MSB
      OP_ROL  = 3'b100,  // rotate left, MSB wraps to LSB
      OP_SHR1 = 3'b101,  // shift right, one into MSB
      OP_SHL1 = 3'b110,  // shift left, one into LSB
      OP_LOAD = 3'b111   // parallel load
   } usr_op_e;

endpackage : usr_pkg

// File: rtl/usr_bit_cell.sv
// One bit of the universal shift register: an 8:1 next-state mux feeding a single flop.
// Interior cells see the same neighbour on all three "from" inputs of a side; the end cells
// get zero, wrap-around and one sources wired separately at the top level.
module usr_bit_cell
   import usr_pkg::*;
(
   input  logic       clk,
   input  logic       clear,          // synchronous, active-high
   input  logic [2:0] select,
   input  logic       parallel_bit,
   input  logic       from_left_zero, // enters on right shift with zero fill
   input  logic       from_left_rot,  // enters on rotate right
   input  logic       from_left_one,  // enters on right shift with one fill
   input  logic       from_right_zero,// enters on left shift with zero fill
   input  logic       from_right_rot, // enters on rotate left
   input  logic       from_right_one, // enters on left shift with one fill
   output logic       q
);

   logic q_next;

   // Select the next value of this bit from the opcode.
   always_comb begin
      // NOTE: q_next gets a default before the case so no path leaves it unassigned (no latch);
      // an X/Z select matches no item and falls through to hold.
      q_next = q;
      case (select)
         OP_HOLD: q_next = q;
         OP_SHR0: q_next = from_left_zero;
         OP_SHL0: q_next = from_right_zero;
         OP_ROR:  q_next = from_left_rot;
         OP_ROL:  q_next = from_right_rot;
         OP_SHR1: q_next = from_left_one;
         OP_SHL1: q_next = from_right_one;
         OP_LOAD: q_next = parallel_bit;
         default: q_next = q;
      endcase
   end

   // Register the bit; clear wins over any opcode.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignment so every cell samples its neighbours' old values on the same edge.
      if (clear) q <= 1'b0;
      else       q <= q_next;
   end

endmodule : usr_bit_cell

// File: rtl/universal_shift_reg_4bit.sv
// Universal shift register: hold, logical shifts, rotates, one-fill shifts and parallel load.
// Built from WIDTH bit cells; data comes straight from the cell flops.
module universal_shift_reg_4bit
   import usr_pkg::*;
#(
   parameter int WIDTH = USR_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [2:0]       select,
   input  logic [WIDTH-1:0] parallel_in,
   output logic [WIDTH-1:0] data
);

   // Wire each cell to its neighbours; end cells receive fill constants and wrap-around bits.
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      logic l_zero, l_rot, l_one;  // source for right shifts (comes from bit i+1)
      logic r_zero, r_rot, r_one;  // source for left shifts (comes from bit i-1)

      if (i == WIDTH - 1) begin : g_msb
         assign l_zero = 1'b0;
         assign l_rot  = data[0];
         assign l_one  = 1'b1;
      end else begin : g_mid_l
         assign l_zero = data[i+1];
         assign l_rot  = data[i+1];
         assign l_one  = data[i+1];
      end

      if (i == 0) begin : g_lsb
         assign r_zero = 1'b0;
         assign r_rot  = data[WIDTH-1];
         assign r_one  = 1'b1;
      end else begin : g_mid_r
         assign r_zero = data[i-1];
         assign r_rot  = data[i-1];
         assign r_one  = data[i-1];
      end

      usr_bit_cell u_cell (
         .clk             (clk),
         .clear           (clear),
         .select          (select),
         .parallel_bit    (parallel_in[i]),
         .from_left_zero  (l_zero),
         .from_left_rot   (l_rot),
         .from_left_one   (l_one),
         .from_right_zero (r_zero),
         .from_right_rot  (r_rot),
         .from_right_one  (r_one),
         .q               (data[i])
      );
   end

endmodule : universal_shift_reg_4bit

// File: tb/tb_universal_shift_reg_4bit.sv
// Directed bench for universal_shift_reg_4bit with hand-computed expected values.
module tb_universal_shift_reg_4bit;

   logic       clk = 1'b0;
   logic       clear;
   logic [2:0] select;
   logic [3:0] parallel_in;
   logic [3:0] data;

   int compared   = 0;
   int mismatched = 0;

   universal_shift_reg_4bit #(.WIDTH(4)) dut (
      .clk         (clk),
      .clear       (clear),
      .select      (select),
      .parallel_in (parallel_in),
      .data        (data)
   );

   always #5 clk = ~clk;

   // Apply one edge with the given controls, then sample 1 time unit after it.
   task automatic step(input logic clr, input logic [2:0] sel, input logic [3:0] pin);
      clear       = clr;
      select      = sel;
      parallel_in = pin;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [3:0] expected);
      compared++;
      assert (data === expected)
      else begin
         mismatched++;
         $error("FAIL %s: observed %b expected %b", tag, data, expected);
      end
   endtask

   task automatic op(input string tag, input logic [2:0] sel, input logic [3:0] expected);
      step(1'b0, sel, 4'b0000);
      check(tag, expected);
   endtask

   task automatic load(input string tag, input logic [3:0] value);
      step(1'b0, 3'b111, value);
      check(tag, value);
   endtask

   initial begin
      clear = 1'b0; select = 3'b000; parallel_in = 4'b0000;
      @(negedge clk);

      // Reset
      step(1'b1, 3'b000, 4'b0000);       check("clear_hold", 4'b0000);
      step(1'b1, 3'b111, 4'b1111);       check("clear_over_load", 4'b0000);

      // Load / hold
      load("load_1011", 4'b1011);
      op("hold1", 3'b000, 4'b1011);
      op("hold2", 3'b000, 4'b1011);
      op("hold3", 3'b000, 4'b1011);

      // Zero-fill shift right, saturating at zero
      load("load_1111_a", 4'b1111);
      op("shr0_1", 3'b001, 4'b0111);
      op("shr0_2", 3'b001, 4'b0011);
      op("shr0_3", 3'b001, 4'b0001);
      op("shr0_4", 3'b001, 4'b0000);
      op("shr0_sat", 3'b001, 4'b0000);

      // Zero-fill shift left
      load("load_1111_b", 4'b1111);
      op("shl0_1", 3'b010, 4'b1110);
      op("shl0_2", 3'b010, 4'b1100);
      op("shl0_3", 3'b010, 4'b1000);
      op("shl0_4", 3'b010, 4'b0000);
      op("shl0_sat", 3'b010, 4'b0000);

      // Single rotates
      load("load_1000_a", 4'b1000);
      op("ror_1000", 3'b011, 4'b0100);
      load("load_1000_b", 4'b1000);
      op("rol_1000", 3'b100, 4'b0001);

      // Full-turn rotates are lossless
      load("load_1001_a", 4'b1001);
      op("ror_x1", 3'b011, 4'b1100);
      op("ror_x2", 3'b011, 4'b0110);
      op("ror_x3", 3'b011, 4'b0011);
      op("ror_x4", 3'b011, 4'b1001);
      load("load_1101", 4'b1101);
      op("rol_x1", 3'b100, 4'b1011);
      op("rol_x2", 3'b100, 4'b0111);
      op("rol_x3", 3'b100, 4'b1110);
      op("rol_x4", 3'b100, 4'b1101);

      // One-fill shifts, saturating at all-ones
      load("load_1000_c", 4'b1000);
      op("shr1_1", 3'b101, 4'b1100);
      op("shr1_2", 3'b101, 4'b1110);
      op("shr1_3", 3'b101, 4'b1111);
      op("shr1_sat", 3'b101, 4'b1111);
      load("load_1000_d", 4'b1000);
      op("shl1_1", 3'b110, 4'b0001);
      op("shl1_2", 3'b110, 4'b0011);
      op("shl1_3", 3'b110, 4'b0111);
      op("shl1_4", 3'b110, 4'b1111);
      op("shl1_sat", 3'b110, 4'b1111);

      // Clear in the middle of shifting, then load zero
      load("load_1111_c", 4'b1111);
      op("mid_shr", 3'b001, 4'b0111);
      step(1'b1, 3'b001, 4'b0000);       check("mid_clear", 4'b0000);
      step(1'b0, 3'b111, 4'b0000);       check("post_clear_load0", 4'b0000);

      // Opcode changing every cycle
      load("load_0110", 4'b0110);
      op("mix_shr0", 3'b001, 4'b0011);
      op("mix_shl0", 3'b010, 4'b0110);
      op("mix_rol",  3'b100, 4'b1100);
      op("mix_ror",  3'b011, 4'b0110);
      op("mix_shl1", 3'b110, 4'b1101);
      op("mix_shr1", 3'b101, 4'b1110);
      op("mix_hold", 3'b000, 4'b1110);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule : tb_universal_shift_reg_4bit
